// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter
//   Round-robin arbiter that shares one 16-bit carry-lookahead adder between
//   NREQ requesters. It issues at most one grant per cycle. Sum, signed
//   overflow and requester ID land in a one-deep output register, which the
//   consumer drains with a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[NREQ]     requester i presents an operand pair
//   req_a/req_b         packed operands, requester i at [16*i +: 16]
//   req_ready[NREQ]     one-hot (or zero) grant, combinational
//   rsp_valid/rsp_ready output register handshake
//   rsp_sum/ovf/id      registered result and the requester that produced it
//   op_count            accepted requests, saturating at 16'hFFFF

// 16-bit adder: four 4-bit lookahead groups, group carries also lookahead
module adder_rr_cla16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum,
    output logic        o_ovf
);
    logic [15:0] w_g, w_p, w_c;
    logic [2:0]  w_gg, w_pg;
    logic [3:0]  w_bc;

    always_comb begin
        w_g = i_a & i_b;
        w_p = i_a ^ i_b;
        w_gg = '0;
        w_pg = '0;
        w_bc = '0;
        w_c  = '0;
        for (int k = 0; k < 3; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_pg[k] = &w_p[4*k +: 4];
        end
        // carry-in is 0, so group carries fold to generate terms only
        w_bc[0] = 1'b0;
        for (int k = 0; k < 3; k++)
            w_bc[k+1] = w_gg[k] | (w_pg[k] & w_bc[k]);
        for (int k = 0; k < 4; k++) begin
            w_c[4*k]   = w_bc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_bc[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_bc[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_bc[k]);
        end
        o_sum = w_p ^ w_c;
        o_ovf = (~i_a[15] & ~i_b[15] & o_sum[15]) | (i_a[15] & i_b[15] & ~o_sum[15]);
    end
endmodule

module adder_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_ovf,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          op_count
);
    logic            r_rsp_valid, r_rsp_ovf;
    logic [15:0]     r_rsp_sum, r_op_count;
    logic [IDW-1:0]  r_rsp_id, r_rr_ptr;

    logic            w_issue_ok, w_found, w_grant, w_ovf;
    logic [IDW-1:0]  w_gidx, w_ptr_nxt;
    logic [NREQ-1:0] w_ready;
    logic [15:0]     w_a, w_b, w_sum;
    logic [15:0]     w_a_arr [NREQ];
    logic [15:0]     w_b_arr [NREQ];

    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_unpack
            assign w_a_arr[i] = req_a[16*i +: 16];
            assign w_b_arr[i] = req_b[16*i +: 16];
        end
    endgenerate

    assign w_issue_ok = !r_rsp_valid || rsp_ready;

    // Scan from rr_ptr with modulo-NREQ wrap; first active requester wins
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) v_idx = v_idx - NREQ;
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_gidx  = IDW'(v_idx);
            end
        end
    end

    // rst_n gate keeps req_ready low while reset is held
    always_comb begin
        w_ready = '0;
        if (rst_n && w_issue_ok && w_found) w_ready[w_gidx] = 1'b1;
    end

    assign w_grant   = |w_ready;
    assign w_ptr_nxt = (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
    assign w_a       = w_a_arr[w_gidx];
    assign w_b       = w_b_arr[w_gidx];

    adder_rr_cla16 u_add (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_id    <= '0;
            r_op_count  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant) begin
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum;
            r_rsp_ovf   <= w_ovf;
            r_rsp_id    <= w_gidx;
            r_rr_ptr    <= w_ptr_nxt;
            if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
        end else if (rsp_ready) begin
            // drained with nothing new: data fields keep their last value
            r_rsp_valid <= 1'b0;
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_id    = r_rsp_id;
    assign op_count  = r_op_count;
endmodule
